mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single line-wide memory port between the instruction-cache refill path and the data-cache miss/eviction path.
- The data-cache path is fed by the exe/tl stage load/store traffic.
- Sequences each D-cache miss as an optional dirty-line writeback followed by a line fill.
- Arbitrates round-robin when both caches miss together. Raises busy_o so the core stall logic can hold the pipeline.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits (power of two, at least 32).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ic_req_i  in  1  I-cache miss request; level, held until ic_ack_o.
- ic_addr_i  in  ADDR_W  I-cache miss address.
- ic_ack_o  out  1  one-cycle pulse; ic_line_o valid this cycle.
- ic_line_o  out  LINE_W  refill line for the I-cache.
- dc_req_i  in  1  D-cache miss request; level, held until dc_ack_o.
- dc_addr_i  in  ADDR_W  D-cache miss address.
- dc_wb_i  in  1  victim line is dirty; write back before fill.
- dc_wb_addr_i  in  ADDR_W  victim line address.
- dc_wb_line_i  in  LINE_W  victim line data.
- dc_ack_o  out  1  one-cycle pulse; dc_line_o valid this cycle.
- dc_line_o  out  LINE_W  refill line for the D-cache.
- mem_req_o  out  1  memory transaction valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  line-aligned memory address.
- mem_wdata_o  out  LINE_W  write data.
- mem_ready_i  in  1  memory completes the transaction this cycle; read data valid.
- mem_rdata_i  in  LINE_W  read line.
- busy_o  out  1  arbiter not in IDLE.
- grant_dc_o  out  1  current/last grant is the D-cache.

Behaviour:
- All outputs registered.
- Reset (async, rst_i=1), all outputs 0:
  - FSM=IDLE; mem_req_o, mem_we_o, ic_ack_o, dc_ack_o, busy_o, grant_dc_o = 0.
  - mem_addr_o, mem_wdata_o, ic_line_o, dc_line_o = 0.
  - last_grant = IC.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE, on requests:
  - No request: stay in IDLE.
  - Only one requester: grant it.
  - Both requesters: grant the one opposite last_grant. After reset the D-cache wins the first tie.
  - On grant: latch the requester id, miss address and, for D, the wb address/data. Update last_grant; set grant_dc_o; busy_o=1.
- IDLE, next state:
  - D-cache grant with dc_wb_i=1: go to WB.
  - Otherwise: go to FILL.
- WB:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o = latched wb address, mem_wdata_o = latched victim line.
  - On mem_ready_i=1: go to FILL.
- FILL:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o = latched miss address.
  - On mem_ready_i=1: capture mem_rdata_i into the granted line output; go to RESP.
- RESP:
  - mem_req_o=0; pulse ic_ack_o or dc_ack_o for exactly one cycle; go to IDLE.
  - busy_o is still 1 in RESP and drops to 0 in IDLE.
- Address alignment: low log2(LINE_W/8) bits of mem_addr_o forced to 0.
- Memory handshake:
  - mem_addr_o, mem_wdata_o and mem_we_o stay stable while mem_req_o=1 and mem_ready_i=0.
  - mem_ready_i is ignored while mem_req_o=0.
- Latency with mem_ready_i tied 1:
  - Request seen in IDLE at edge n gives ack high in cycle n+2.
  - With writeback, ack high in cycle n+3.
  - Each wait cycle on mem_ready_i adds 1.
- Requester rule: req must be low in the cycle after its ack. The arbiter samples in IDLE only, so a still-high req restarts a new transaction (legal back-to-back miss).
- Request changes:
  - A req dropping before ack is a protocol violation; the arbiter completes the transaction anyway.
  - A request arriving during a transaction waits; fairness is applied at the next IDLE.
- Line outputs hold their last value between acks.
- Reset mid-operation:
  - mem_req_o drops immediately (asynchronous); no ack is issued.
  - The pending transaction is discarded; requesters re-issue after reset.

Test Plan:
- IC miss: ic_req_i=1, ic_addr_i=0x0000_1234, mem_ready_i high after 3 wait cycles, rdata=0xDEADBEEF_…_01 -> mem_addr_o=0x0000_1230, mem_we_o=0, ic_ack_o one pulse with ic_line_o=rdata, busy_o low the cycle after.
- DC dirty miss: dc_wb_i=1, dc_wb_addr_i=0x80, dc_addr_i=0x200, ready tied 1 -> write to 0x80 with dc_wb_line_i, then read 0x200; dc_ack_o in cycle n+3.
- Simultaneous first tie after reset: ic and dc requests together -> DC served first, IC second. Both re-request together -> IC first (alternation).
- Back-to-back: dc_req_i held high across its ack while ic_req_i also high -> IC granted next (round-robin), not DC twice.
- Reset mid-FILL: assert rst_i during FILL with mem_ready_i=0 -> mem_req_o=0 the same cycle, no ack. After release, everything is idle and busy_o=0.
- Stall on mem_ready_i: hold ready low 10 cycles in WB -> mem_addr_o, mem_wdata_o and mem_we_o stable throughout, no ack until FILL completes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between I-cache refills and D-cache miss
// handling (optional dirty writeback then fill), round-robin on ties.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_ack_o,
   output logic [LINE_W-1:0] ic_line_o,
   input  logic              dc_req_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic              dc_wb_i,
   input  logic [ADDR_W-1:0] dc_wb_addr_i,
   input  logic [LINE_W-1:0] dc_wb_line_i,
   output logic              dc_ack_o,
   output logic [LINE_W-1:0] dc_line_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              grant_dc_o
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W/8 - 1);

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

   state_t            r_state, w_state;
   logic              r_last_dc, w_last_dc;
   logic              r_gnt_dc, w_gnt_dc;
   logic [ADDR_W-1:0] r_miss_addr, w_miss_addr;
   logic              r_mem_req, w_mem_req;
   logic              r_mem_we, w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
   logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata;
   logic              r_ic_ack, w_ic_ack;
   logic              r_dc_ack, w_dc_ack;
   logic [LINE_W-1:0] r_ic_line, w_ic_line;
   logic [LINE_W-1:0] r_dc_line, w_dc_line;
   logic              r_busy, w_busy;
   logic              w_sel_dc;

   // On a tie the requester opposite the previous grant wins.
   assign w_sel_dc = dc_req_i & (~ic_req_i | ~r_last_dc);

   always_comb begin
      w_state     = r_state;
      w_last_dc   = r_last_dc;
      w_gnt_dc    = r_gnt_dc;
      w_miss_addr = r_miss_addr;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_ic_ack    = 1'b0;
      w_dc_ack    = 1'b0;
      w_ic_line   = r_ic_line;
      w_dc_line   = r_dc_line;
      w_busy      = r_busy;
      case (r_state)
         S_IDLE: begin
            if (ic_req_i || dc_req_i) begin
               w_gnt_dc    = w_sel_dc;
               w_last_dc   = w_sel_dc;
               w_miss_addr = (w_sel_dc ? dc_addr_i : ic_addr_i) & ALIGN_MASK;
               w_mem_req   = 1'b1;
               w_busy      = 1'b1;
               if (w_sel_dc && dc_wb_i) begin
                  w_state     = S_WB;
                  w_mem_we    = 1'b1;
                  w_mem_addr  = dc_wb_addr_i & ALIGN_MASK;
                  w_mem_wdata = dc_wb_line_i;
               end else begin
                  w_state    = S_FILL;
                  w_mem_we   = 1'b0;
                  w_mem_addr = w_miss_addr;
               end
            end
         end
         S_WB: begin
            if (mem_ready_i) begin
               w_state    = S_FILL;
               w_mem_we   = 1'b0;
               w_mem_addr = r_miss_addr;
            end
         end
         S_FILL: begin
            if (mem_ready_i) begin
               w_state   = S_RESP;
               w_mem_req = 1'b0;
               if (r_gnt_dc) begin
                  w_dc_line = mem_rdata_i;
                  w_dc_ack  = 1'b1;
               end else begin
                  w_ic_line = mem_rdata_i;
                  w_ic_ack  = 1'b1;
               end
            end
         end
         S_RESP: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_last_dc   <= 1'b0;
         r_gnt_dc    <= 1'b0;
         r_miss_addr <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_ic_ack    <= 1'b0;
         r_dc_ack    <= 1'b0;
         r_ic_line   <= '0;
         r_dc_line   <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_last_dc   <= w_last_dc;
         r_gnt_dc    <= w_gnt_dc;
         r_miss_addr <= w_miss_addr;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_ic_ack    <= w_ic_ack;
         r_dc_ack    <= w_dc_ack;
         r_ic_line   <= w_ic_line;
         r_dc_line   <= w_dc_line;
         r_busy      <= w_busy;
      end
   end

   assign ic_ack_o    = r_ic_ack;
   assign ic_line_o   = r_ic_line;
   assign dc_ack_o    = r_dc_ack;
   assign dc_line_o   = r_dc_line;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign busy_o      = r_busy;
   assign grant_dc_o  = r_gnt_dc;

endmodule
